ip_uart_rx: RTL and testbench

//  Receive half of the cartridge debug UART: 8N1 asynchronous serial, LSB first. Pairs with the ip_uart transmitter.

---
 rtl/ip_uart_rx.sv | 157 +++++++++++++++
 tb/tb_ip_uart_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ip_uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, 3-sample majority vote at each bit centre,
// and a single-byte holding register behind a valid/ack handshake.
module ip_uart_rx #(
  parameter int clk_freq  = 27000000,
  parameter int uart_freq = 115200
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       uart_rx,
  output logic [7:0] recv_data,
  output logic       recv_valid,
  input  logic       recv_ack,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);
  localparam int DIV  = clk_freq / uart_freq;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(10 * DIV + HALF + 2);

  localparam logic [CW-1:0] DIV_W  = CW'(DIV);
  localparam logic [CW-1:0] HALF_W = CW'(HALF);
  localparam logic [CW-1:0] ONE_W  = CW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // Handshake: a byte is held while recv_valid=1; the consumer takes it by raising
  // recv_ack in a cycle where recv_valid=1, and recv_valid drops on the next cycle.
  logic          rx_meta_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] centre_q, centre_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    samp_q, samp_d;
  logic [7:0]    shift_q, shift_d;
  logic          deliver_q, deliver_d;
  logic          framing_error_q, framing_error_d;
  logic [7:0]    recv_data_q, recv_data_d;
  logic          recv_valid_q, recv_valid_d;
  logic          overrun_q, overrun_d;
  logic          decide, vote;

  // The decision cycle votes with the two stored samples plus the current one.
  assign decide = (cnt_q == centre_q + ONE_W);
  assign vote   = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s_q) | (samp_q[0] & rx_s_q);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + ONE_W;
    centre_d        = centre_q;
    bit_d           = bit_q;
    samp_d          = samp_q;
    shift_d         = shift_q;
    deliver_d       = 1'b0;
    framing_error_d = 1'b0;
    if (cnt_q == centre_q - ONE_W) samp_d[1] = rx_s_q;
    if (cnt_q == centre_q)         samp_d[0] = rx_s_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = ONE_W;
        if (!rx_s_q) begin
          state_d  = S_START;
          centre_d = HALF_W;
          bit_d    = 3'd0;
        end
      end
      S_START: begin
        if (decide) begin
          state_d  = vote ? S_IDLE : S_DATA;
          centre_d = centre_q + DIV_W;
        end
      end
      S_DATA: begin
        if (decide) begin
          shift_d  = {vote, shift_q[7:1]};
          centre_d = centre_q + DIV_W;
          bit_d    = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          if (vote) begin
            deliver_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // An ack landing in the delivery cycle frees the register for the new byte.
  always_comb begin
    recv_data_d  = recv_data_q;
    recv_valid_d = recv_valid_q;
    overrun_d    = 1'b0;
    if (deliver_q) begin
      if (!recv_valid_q || recv_ack) begin
        recv_data_d  = shift_q;
        recv_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (recv_valid_q && recv_ack) begin
      recv_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      centre_q        <= '0;
      bit_q           <= 3'd0;
      samp_q          <= 2'b11;
      shift_q         <= 8'h00;
      deliver_q       <= 1'b0;
      framing_error_q <= 1'b0;
      recv_data_q     <= 8'h00;
      recv_valid_q    <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      rx_meta_q       <= uart_rx;
      rx_s_q          <= rx_meta_q;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      centre_q        <= centre_d;
      bit_q           <= bit_d;
      samp_q          <= samp_d;
      shift_q         <= shift_d;
      deliver_q       <= deliver_d;
      framing_error_q <= framing_error_d;
      recv_data_q     <= recv_data_d;
      recv_valid_q    <= recv_valid_d;
      overrun_q       <= overrun_d;
    end
  end

  assign recv_data     = recv_data_q;
  assign recv_valid    = recv_valid_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_ip_uart_rx.sv
// Directed and randomized frames for ip_uart_rx at default parameters (one bit = 234 clk).
module tb_ip_uart_rx;
  localparam int BIT = 234;
  localparam int HALF_BIT = 117;
  // Delivery cycle measured from the pin edge: 2 sync cycles + stop decision (9*BIT+HALF+1) + 1.
  localparam int DELIVER_OFS = 2 + 9 * BIT + HALF_BIT + 2;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] recv_data;
  logic       recv_valid;
  logic       recv_ack = 1'b0;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, busy_rise_cnt = 0, valid_rise_cyc = 0;
  logic busy_prev = 1'b0, valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  ip_uart_rx dut (
    .clk(clk), .n_reset(n_reset), .uart_rx(uart_rx), .recv_data(recv_data),
    .recv_valid(recv_valid), .recv_ack(recv_ack), .framing_error(framing_error),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (busy && !busy_prev) busy_rise_cnt++;
    if (recv_valid && !valid_prev) valid_rise_cyc = cyc;
    busy_prev  = busy;
    valid_prev = recv_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one 8N1 frame with a bit length of bl clk.
  task automatic send_frame(input logic [7:0] d, input int bl, input logic stop_v);
    start_cyc = cyc;
    uart_rx = 1'b0;
    repeat (bl) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (bl) @(negedge clk);
    end
    uart_rx = stop_v;
    repeat (bl) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!recv_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!recv_valid) check(tag, 32'(recv_valid), 32'd1);
  endtask

  task automatic do_ack(input string tag, input logic [7:0] held);
    recv_ack = 1'b1;
    @(negedge clk);
    recv_ack = 1'b0;
    check({tag, "_valid_drop"}, 32'(recv_valid), 32'd0);
    check({tag, "_data_kept"}, 32'(recv_data), 32'(held));
  endtask

  // Reference: a frame with stop=1 delivers exactly the byte sent, in order.
  task automatic frame_and_check(input string tag, input logic [7:0] d, input int bl);
    logic [7:0] e;
    exp_q.push_back(d);
    send_frame(d, bl, 1'b1);
    wait_valid({tag, "_timeout"}, 500);
    e = exp_q.pop_front();
    check({tag, "_data"}, 32'(recv_data), 32'(e));
    do_ack(tag, e);
  endtask

  initial begin
    int fe0, ov0, br0, guard, bl, gap;
    logic [7:0] d;
    logic [7:0] pats[3];
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'hC3;

    repeat (4) @(negedge clk);
    check("rst_data", 32'(recv_data), 32'h00);
    check("rst_valid", 32'(recv_valid), 32'd0);
    check("rst_fe", 32'(framing_error), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    n_reset = 1'b1;
    repeat (20) @(negedge clk);

    // Nominal frame, latency, hold until ack
    exp_q.push_back(8'h48);
    fork
      send_frame(8'h48, BIT, 1'b1);
      begin
        repeat (5 * BIT) @(negedge clk);
        check("t1_busy_mid", 32'(busy), 32'd1);
      end
    join
    wait_valid("t1_timeout", 500);
    check("t1_latency_about_2222", 32'((valid_rise_cyc - start_cyc) >= 2212 &&
                                       (valid_rise_cyc - start_cyc) <= 2240), 32'd1);
    check("t1_data", 32'(recv_data), 32'(exp_q.pop_front()));
    check("t1_busy_after", 32'(busy), 32'd0);
    repeat (100) @(negedge clk);
    check("t1_valid_held", 32'(recv_valid), 32'd1);
    do_ack("t1", 8'h48);

    // Short low glitch: false start
    fe0 = fe_cnt; br0 = busy_rise_cnt;
    uart_rx = 1'b0;
    repeat (50) @(negedge clk);
    uart_rx = 1'b1;
    repeat (400) @(negedge clk);
    check("t2_busy_pulse", 32'(busy_rise_cnt - br0), 32'd1);
    check("t2_busy_idle", 32'(busy), 32'd0);
    check("t2_valid", 32'(recv_valid), 32'd0);
    check("t2_fe", 32'(fe_cnt - fe0), 32'd0);

    // Framing error followed by a held-low break
    fe0 = fe_cnt; br0 = busy_rise_cnt;
    send_frame(8'h55, BIT, 1'b0);
    repeat (2000) @(negedge clk);
    check("t3_fe_once", 32'(fe_cnt - fe0), 32'd1);
    check("t3_valid", 32'(recv_valid), 32'd0);
    check("t3_no_restart", 32'(busy_rise_cnt - br0), 32'd1);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_busy_released", 32'(busy), 32'd0);
    repeat (300) @(negedge clk);
    check("t3_fe_still_once", 32'(fe_cnt - fe0), 32'd1);

    // Back-to-back without ack: overrun, first byte kept
    ov0 = ov_cnt;
    send_frame(8'h12, BIT, 1'b1);
    send_frame(8'h34, BIT, 1'b1);
    repeat (20) @(negedge clk);
    check("t4a_data", 32'(recv_data), 32'h12);
    check("t4a_valid", 32'(recv_valid), 32'd1);
    check("t4a_overrun", 32'(ov_cnt - ov0), 32'd1);
    do_ack("t4a", 8'h12);
    repeat (300) @(negedge clk);

    // Back-to-back with ack in the delivery cycle of the second byte
    ov0 = ov_cnt;
    send_frame(8'h12, BIT, 1'b1);
    fork
      send_frame(8'h34, BIT, 1'b1);
      begin
        @(negedge clk);
        guard = 0;
        while (cyc != start_cyc + DELIVER_OFS && guard < 5000) begin
          @(negedge clk);
          guard++;
        end
        recv_ack = 1'b1;
        @(negedge clk);
        recv_ack = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("t4b_data", 32'(recv_data), 32'h34);
    check("t4b_valid", 32'(recv_valid), 32'd1);
    check("t4b_no_overrun", 32'(ov_cnt - ov0), 32'd0);
    repeat (300) @(negedge clk);

    // Reset pulse during data bit 3 (recv_valid still holds 0x34)
    fork
      send_frame(8'hF8, BIT, 1'b1);
      begin
        @(negedge clk);
        guard = 0;
        while (cyc != start_cyc + 2 + 4 * BIT + HALF_BIT && guard < 5000) begin
          @(negedge clk);
          guard++;
        end
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        check("t5_rst_data", 32'(recv_data), 32'h00);
        check("t5_rst_valid", 32'(recv_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_flags", 32'({framing_error, overrun}), 32'd0);
      end
    join
    repeat (300) @(negedge clk);
    check("t5_no_partial", 32'(recv_valid), 32'd0);
    frame_and_check("t5_a5", 8'hA5, BIT);
    repeat (50) @(negedge clk);

    // Baud +/-3%
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 3; i++) begin
      frame_and_check("t6_fast", pats[i], 227);
      repeat (40) @(negedge clk);
      frame_and_check("t6_slow", pats[i], 241);
      repeat (40) @(negedge clk);
    end
    check("t6_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check("t6_no_ov", 32'(ov_cnt - ov0), 32'd0);

    // Random bytes, random baud within tolerance, random idle gaps
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 10; i++) begin
      d   = 8'($urandom_range(0, 255));
      bl  = $urandom_range(227, 241);
      gap = $urandom_range(0, 60);
      repeat (gap) @(negedge clk);
      frame_and_check("rand", d, bl);
    end
    check("rand_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check("rand_no_ov", 32'(ov_cnt - ov0), 32'd0);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
